// File: rtl/frame_builder.sv
// Byte framer: preamble, sync word, length, payload and CRC-8 into one
// output register that honours downstream ready as backpressure.
module frame_builder #(
  parameter int unsigned PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [15:0] SYNC_WORD     = 16'hD391
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_len,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_SYNC_HI  = 3'd2;
  localparam logic [2:0] S_SYNC_LO  = 3'd3;
  localparam logic [2:0] S_LEN      = 3'd4;
  localparam logic [2:0] S_PAYLOAD  = 3'd5;
  localparam logic [2:0] S_CRC      = 3'd6;

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] len_q, len_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       crc_sent_q, crc_sent_d;
  logic       slot_free;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign slot_free = !valid_q || i_ready;
  assign o_ready   = (state_q == S_PAYLOAD) && slot_free;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_error   = error_q;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    len_d      = len_q;
    rem_d      = rem_q;
    crc_d      = crc_q;
    data_d     = data_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    crc_sent_d = crc_sent_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // First preamble byte loads with the start so it shows next cycle
        if (i_start) begin
          if (i_len != 8'd0) begin
            data_d    = PREAMBLE_BYTE;
            valid_d   = 1'b1;
            pre_cnt_d = 4'd1;
            len_d     = i_len;
            crc_d     = 8'h00;
            busy_d    = 1'b1;
            state_d   = (PREAMBLE_LEN == 1) ? S_SYNC_HI : S_PREAMBLE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (slot_free) begin
          data_d    = PREAMBLE_BYTE;
          valid_d   = 1'b1;
          pre_cnt_d = pre_cnt_q + 4'd1;
          if (pre_cnt_q == PRE_LAST) state_d = S_SYNC_HI;
        end
      end
      S_SYNC_HI: begin
        if (slot_free) begin
          data_d  = SYNC_WORD[15:8];
          valid_d = 1'b1;
          state_d = S_SYNC_LO;
        end
      end
      S_SYNC_LO: begin
        if (slot_free) begin
          data_d  = SYNC_WORD[7:0];
          valid_d = 1'b1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (slot_free) begin
          data_d  = len_q;
          valid_d = 1'b1;
          crc_d   = crc8(crc_q, len_q);
          rem_d   = len_q;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (slot_free) begin
          if (i_valid) begin
            data_d  = i_data;
            valid_d = 1'b1;
            crc_d   = crc8(crc_q, i_data);
            rem_d   = rem_q - 8'd1;
            if (rem_q == 8'd1) state_d = S_CRC;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      S_CRC: begin
        // Load the checksum once, then wait for it to leave
        if (!crc_sent_q) begin
          if (slot_free) begin
            data_d     = crc_q;
            valid_d    = 1'b1;
            crc_sent_d = 1'b1;
          end
        end else if (i_ready) begin
          valid_d    = 1'b0;
          crc_sent_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        crc_sent_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= 4'd0;
      len_q      <= 8'h00;
      rem_q      <= 8'h00;
      crc_q      <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      crc_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      crc_q      <= crc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      crc_sent_q <= crc_sent_d;
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Randomized bench for frame_builder against a queue-based frame model
// built from the framing and CRC-8 rules.
module tb_frame_builder;

  localparam int PRE_LEN = 4;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_len;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  int checks_n;
  int errors_n;

  bq_t pl;
  bq_t got;

  frame_builder dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_len   (i_len),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_error (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    checks_n++;
    if (got_v !== exp_v) begin
      errors_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // CRC as polynomial division, one message bit at a time
  function automatic logic [7:0] ref_crc(input bq_t msg);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ msg[i][b];
        c  = c << 1;
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  function automatic bq_t ref_frame(input bq_t p);
    bq_t f;
    bq_t m;
    m.push_back(8'(p.size()));
    foreach (p[i]) m.push_back(p[i]);
    for (int i = 0; i < PRE_LEN; i++) f.push_back(8'h55);
    f.push_back(8'hD3);
    f.push_back(8'h91);
    foreach (m[i]) f.push_back(m[i]);
    f.push_back(ref_crc(m));
    return f;
  endfunction

  task automatic run_frame(input int len, input int rmode,
                           input int gap_at, input int gap_len,
                           input bit swb, input bit started,
                           input int next_len);
    bq_t  exp_f;
    int   idx;
    int   cyc;
    int   gcnt;
    bit   in_gap;
    bit   done;
    bit   prev_stall;
    logic [7:0] held;
    exp_f = ref_frame(pl);
    got.delete();
    idx = 0; cyc = 0; gcnt = 0; done = 0; prev_stall = 0; held = 8'h00;
    if (!started) begin
      i_start = 1'b1;
      i_len   = 8'(len);
      i_valid = 1'b0;
    end
    while (!done && cyc < 4000) begin
      @(posedge clk); #1;
      i_start = swb && (cyc == PRE_LEN + 3);
      i_len   = i_start ? 8'd7 : 8'd0;
      case (rmode)
        0: i_ready = 1'b1;
        1: i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      in_gap = 0;
      if (idx == gap_at && gcnt < gap_len) begin
        in_gap = 1;
        gcnt++;
      end
      if (idx < len && !in_gap) begin
        i_valid = 1'b1;
        i_data  = pl[idx];
      end else begin
        i_valid = 1'b0;
        i_data  = 8'($urandom);
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk("first_busy", 32'(o_busy), 32'd1);
        chk("first_valid", 32'(o_valid), 32'd1);
        chk("first_data", 32'(o_data), 32'h55);
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", 32'(o_data), 32'(held));
      end
      if (in_gap && rmode == 0) begin
        chk("gap_ready", 32'(o_ready), 32'd1);
        if (gcnt > 1) chk("gap_valid", 32'(o_valid), 32'd0);
      end
      prev_stall = o_valid && !i_ready;
      held = o_data;
      if (i_valid && o_ready) idx++;
      if (o_valid && i_ready) got.push_back(o_data);
      if (o_done) begin
        done = 1;
        chk("done_busy", 32'(o_busy), 32'd0);
        if (rmode == 0 && gap_len == 0)
          chk("done_cycle", 32'(cyc), 32'(PRE_LEN + 4 + len));
      end
      cyc++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    chk("frame_size", 32'(got.size()), 32'(exp_f.size()));
    for (int i = 0; i < exp_f.size() && i < got.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_f[i]));
    if (next_len > 0) begin
      i_start = 1'b1;
      i_len   = 8'(next_len);
      i_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      chk("after_done", 32'(o_done), 32'd0);
      chk("after_busy", 32'(o_busy), 32'd0);
      chk("after_valid", 32'(o_valid), 32'd0);
    end
  endtask

  task automatic check_single;
    logic [7:0] s1 [9];
    s1 = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h01, 8'hA5, 8'h67};
    chk("single_size", 32'(got.size()), 32'd9);
    for (int i = 0; i < 9 && i < got.size(); i++)
      chk($sformatf("single%0d", i), 32'(got[i]), 32'(s1[i]));
  endtask

  initial begin
    int len;
    int gat;
    int glen;
    checks_n = 0;
    errors_n = 0;
    i_reset = 1'b0;
    i_start = 1'b0;
    i_len   = 8'd0;
    i_data  = 8'd0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    i_reset = 1'b1;
    @(posedge clk); #1;

    pl = '{8'hA5};
    run_frame(1, 0, 0, 0, 0, 0, 0);
    check_single();
    run_frame(1, 1, 0, 0, 0, 0, 0);
    check_single();

    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(3, 0, 1, 5, 0, 0, 0);
    run_frame(3, 0, 0, 0, 0, 0, 0);

    @(posedge clk); #1;
    i_start = 1'b1;
    i_len   = 8'd0;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("zero_error", 32'(o_error), 32'd1);
    chk("zero_busy", 32'(o_busy), 32'd0);
    chk("zero_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_error_clr", 32'(o_error), 32'd0);
    chk("zero_valid2", 32'(o_valid), 32'd0);

    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    run_frame(6, 0, 0, 0, 1, 0, 0);

    pl = '{8'hC3, 8'h3C};
    run_frame(2, 0, 0, 0, 0, 0, 2);
    pl = '{8'h0F, 8'hF0};
    run_frame(2, 0, 0, 0, 0, 1, 0);

    pl = '{8'hA5};
    @(posedge clk); #1;
    i_start = 1'b1;
    i_len   = 8'd1;
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      i_valid = 1'b1;
      i_data  = 8'hA5;
      if (c == 4) i_reset = 1'b0;
    end
    @(negedge clk);
    chk("pre_rst_data", 32'(o_data), 32'hD3);
    @(posedge clk); #1;
    i_reset = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_error", 32'(o_error), 32'd0);
    chk("midrst_data", 32'(o_data), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_quiet", 32'({o_valid, o_done}), 32'd0);
    end
    run_frame(1, 0, 0, 0, 0, 0, 0);
    check_single();

    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 40);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      gat  = (len > 1) ? $urandom_range(1, len - 1) : 0;
      glen = (len > 1) ? $urandom_range(0, 5) : 0;
      run_frame(len, $urandom_range(0, 2), gat, glen, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks_n, errors_n);
    $finish;
  end

endmodule
